lcd_rx_monitor: RTL and testbench

Sink end of the parallel RGB LCD interface. It consumes rgb_lcd_24b, hsync, vsync and lcd_de as driven by the LCD controller, then recovers pixel coordinates. It also measures line and frame geometry, flags timing errors, computes a per-frame pixel checksum and captures one probe pixel. It sits on the 33 MHz LCD clock domain beside the LCD controller and is used for on-board self-test and as the bench scoreboard front end.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_rx_edge.sv | 53 +++++
 rtl/lcd_rx_monitor.sv | 192 +++++++++++++++++++
 tb/tb_lcd_rx_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Purpose: shared constants, error bit indices, FSM state type and checksum step for the LCD receive monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_V_ACTIVE = 480;
  localparam int LCD_COORD_W  = 11;

  localparam int ERR_HLEN = 0;
  localparam int ERR_VLEN = 1;
  localparam int ERR_SAT  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Rotate left by one, then fold the pixel into the low 24 bits.
  function automatic logic [31:0] chk_step(input logic [31:0] chk, input logic [23:0] rgb);
    return {chk[30:0], chk[31]} ^ {8'h00, rgb};
  endfunction

endpackage

// File: rtl/lcd_rx_edge.sv
// Purpose: stage-1 capture of the LCD interface, sync polarity normalisation, DE/vsync edge pulses.
// Latency: 1 clk_in for registered signals; edge pulses are combinational from stage 1.
// Backpressure: none, pure sink sampling every cycle.
// Ports: clk_in/sys_rst_n clock and async active-low reset; rgb_lcd_24b/hsync/vsync/lcd_de raw
//        interface; pix_rgb/de stage-1 data; hs_act/vs_act active-high syncs; de_rise/de_fall/
//        vs_lead/vs_trail one-cycle edge pulses derived from stage 1 versus its previous value.
module lcd_rx_edge #(
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic [23:0] rgb_lcd_24b,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        lcd_de,
  output logic [23:0] pix_rgb,
  output logic        de,
  output logic        hs_act,
  output logic        vs_act,
  output logic        de_rise,
  output logic        de_fall,
  output logic        vs_lead,
  output logic        vs_trail
);

  logic de_prev;
  logic vs_prev;

  // Syncs are stored already normalised to active-high so the reset value 0 means "inactive".
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_rgb <= '0;
      de      <= 1'b0;
      hs_act  <= 1'b0;
      vs_act  <= 1'b0;
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      pix_rgb <= rgb_lcd_24b;
      de      <= lcd_de;
      hs_act  <= (hsync == SYNC_ACT);
      vs_act  <= (vsync == SYNC_ACT);
      de_prev <= de;
      vs_prev <= vs_act;
    end
  end

  assign de_rise  = de & ~de_prev;
  assign de_fall  = ~de & de_prev;
  assign vs_lead  = vs_act & ~vs_prev;
  assign vs_trail = ~vs_act & vs_prev;

endmodule

// File: rtl/lcd_rx_monitor.sv
// Purpose: LCD sink monitor; recovers pixel coordinates, measures line/frame geometry, flags errors, checksums frames.
// Latency: pix_valid/pix_x/pix_y/pix_data 2 clk_in after the port signals; frame results on the vsync-lead cycle + 2.
// Backpressure: none, the interface cannot be stalled; every DE cycle is consumed.
// Ports: clk_in, sys_rst_n (async active-low); rgb_lcd_24b/hsync/vsync/lcd_de interface; probe_x/probe_y
//        probe location; err_clr sticky-flag clear; pix_* recovered pixel; frame_done/h_meas/v_meas/
//        frame_chk per-frame results; probe_rgb captured pixel; err_flags sticky errors; locked status.
module lcd_rx_monitor
  import lcd_pkg::*;
#(
  parameter int   H_ACTIVE = LCD_H_ACTIVE,
  parameter int   V_ACTIVE = LCD_V_ACTIVE,
  parameter logic SYNC_ACT = 1'b0,
  parameter int   COORD_W  = LCD_COORD_W
) (
  input  logic               clk_in,
  input  logic               sys_rst_n,
  input  logic [23:0]        rgb_lcd_24b,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               lcd_de,
  input  logic [COORD_W-1:0] probe_x,
  input  logic [COORD_W-1:0] probe_y,
  input  logic               err_clr,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [23:0]        pix_data,
  output logic               pix_valid,
  output logic               frame_done,
  output logic [COORD_W-1:0] h_meas,
  output logic [COORD_W-1:0] v_meas,
  output logic [31:0]        frame_chk,
  output logic [23:0]        probe_rgb,
  output logic [2:0]         err_flags,
  output logic               locked
);

  localparam logic [COORD_W-1:0] CNT_MAX = '1;
  localparam logic [COORD_W-1:0] H_EXP   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_EXP   = COORD_W'(V_ACTIVE);

  logic [23:0] rgb_s1;
  logic        de_s1, hs_s1, vs_s1, de_rise, de_fall, vs_lead, vs_trail;

  lcd_rx_edge #(.SYNC_ACT(SYNC_ACT)) u_edge (
    .clk_in      (clk_in),
    .sys_rst_n   (sys_rst_n),
    .rgb_lcd_24b (rgb_lcd_24b),
    .hsync       (hsync),
    .vsync       (vsync),
    .lcd_de      (lcd_de),
    .pix_rgb     (rgb_s1),
    .de          (de_s1),
    .hs_act      (hs_s1),
    .vs_act      (vs_s1),
    .de_rise     (de_rise),
    .de_fall     (de_fall),
    .vs_lead     (vs_lead),
    .vs_trail    (vs_trail)
  );

  // hsync is captured for completeness but DE alone defines the active region.
  logic unused_edge;
  assign unused_edge = ^{hs_s1, vs_s1, de_rise, vs_trail};

  state_t             state_q, state_n;
  logic [COORD_W-1:0] x_q, y_q, x_w, y_w;
  logic [31:0]        chk_q, chk_w;
  logic               frame_err_q, frame_err_n;
  logic [1:0]         lock_q, lock_n;
  logic [2:0]         err_set, err_n;

  logic [COORD_W-1:0] pix_x_n, pix_y_n, h_meas_n, v_meas_n;
  logic [23:0]        pix_data_n, probe_rgb_n;
  logic               pix_valid_n, frame_done_n;
  logic [31:0]        frame_chk_n;

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      chk_q       <= '0;
      frame_err_q <= 1'b0;
      lock_q      <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      frame_done  <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      frame_chk   <= '0;
      probe_rgb   <= '0;
      err_flags   <= '0;
    end else begin
      state_q     <= state_n;
      x_q         <= x_w;
      y_q         <= y_w;
      chk_q       <= chk_w;
      frame_err_q <= frame_err_n;
      lock_q      <= lock_n;
      pix_x       <= pix_x_n;
      pix_y       <= pix_y_n;
      pix_data    <= pix_data_n;
      pix_valid   <= pix_valid_n;
      frame_done  <= frame_done_n;
      h_meas      <= h_meas_n;
      v_meas      <= v_meas_n;
      frame_chk   <= frame_chk_n;
      probe_rgb   <= probe_rgb_n;
      err_flags   <= err_n;
    end
  end

  // Order inside ACTIVE matters: line close, then frame close, then the current pixel.
  // That lets a line ending on the vsync-lead cycle count in the old frame, and a DE-high
  // pixel on that cycle land at (0,0) of the new frame.
  always_comb begin
    state_n      = state_q;
    x_w          = x_q;
    y_w          = y_q;
    chk_w        = chk_q;
    frame_err_n  = frame_err_q;
    lock_n       = lock_q;
    err_set      = '0;
    pix_valid_n  = 1'b0;
    pix_x_n      = pix_x;
    pix_y_n      = pix_y;
    pix_data_n   = pix_data;
    frame_done_n = 1'b0;
    h_meas_n     = h_meas;
    v_meas_n     = v_meas;
    frame_chk_n  = frame_chk;
    probe_rgb_n  = probe_rgb;

    unique case (state_q)
      IDLE: begin
        if (vs_lead) begin
          state_n     = ACTIVE;
          x_w         = '0;
          y_w         = '0;
          chk_w       = '0;
          frame_err_n = 1'b0;
        end
      end
      ACTIVE: begin
        if (de_fall) begin
          h_meas_n = x_w;
          if (x_w != H_EXP) err_set[ERR_HLEN] = 1'b1;
          x_w = '0;
          if (y_w == CNT_MAX) err_set[ERR_SAT] = 1'b1;
          else                y_w = y_w + 1'b1;
        end
        if (vs_lead) begin
          frame_done_n = 1'b1;
          v_meas_n     = y_w;
          frame_chk_n  = chk_w;
          if (y_w != V_EXP) err_set[ERR_VLEN] = 1'b1;
          x_w   = '0;
          y_w   = '0;
          chk_w = '0;
        end
        if (de_s1) begin
          pix_valid_n = 1'b1;
          pix_x_n     = x_w;
          pix_y_n     = y_w;
          pix_data_n  = rgb_s1;
          chk_w       = chk_step(chk_w, rgb_s1);
          if (x_w == probe_x && y_w == probe_y) probe_rgb_n = rgb_s1;
          if (x_w == CNT_MAX) err_set[ERR_SAT] = 1'b1;
          else                x_w = x_w + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Errors raised on the closing cycle belong to the frame that is closing.
    if (|err_set) begin
      lock_n = '0;
    end else if (frame_done_n && !frame_err_q && lock_q != 2'd2) begin
      lock_n = lock_q + 2'd1;
    end
    if (frame_done_n)  frame_err_n = 1'b0;
    else if (|err_set) frame_err_n = 1'b1;

    // A newly detected error outranks a coincident clear.
    err_n = (err_clr ? 3'b000 : err_flags) | err_set;
  end

  assign locked = (lock_q == 2'd2);

endmodule

// File: tb/tb_lcd_rx_monitor.sv
module tb_lcd_rx_monitor;

  localparam int H  = 40;
  localparam int V  = 6;
  localparam int CW = 11;

  logic          clk_in = 1'b0;
  logic          sys_rst_n;
  logic [23:0]   rgb_lcd_24b;
  logic          hsync, vsync, lcd_de, err_clr;
  logic [CW-1:0] probe_x, probe_y;
  logic [CW-1:0] pix_x, pix_y, h_meas, v_meas;
  logic [23:0]   pix_data, probe_rgb;
  logic          pix_valid, frame_done, locked;
  logic [31:0]   frame_chk;
  logic [2:0]    err_flags;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  int          pv_cnt = 0;
  int          base;
  logic [31:0] acc = 32'h0;
  logic [31:0] last_chk = 32'h0;

  always #5 clk_in = ~clk_in;

  lcd_rx_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACT(1'b0), .COORD_W(CW)) dut (
    .clk_in      (clk_in),
    .sys_rst_n   (sys_rst_n),
    .rgb_lcd_24b (rgb_lcd_24b),
    .hsync       (hsync),
    .vsync       (vsync),
    .lcd_de      (lcd_de),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .err_clr     (err_clr),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .frame_done  (frame_done),
    .h_meas      (h_meas),
    .v_meas      (v_meas),
    .frame_chk   (frame_chk),
    .probe_rgb   (probe_rgb),
    .err_flags   (err_flags),
    .locked      (locked)
  );

  always @(negedge clk_in) begin
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (pix_valid)  pv_cnt = pv_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int y, input int n, input int hblank);
    for (int x = 0; x < n; x++) begin
      lcd_de      = 1'b1;
      rgb_lcd_24b = {x[7:0], y[7:0], 8'hA5};
      acc         = {acc[30:0], acc[31]} ^ {8'h00, rgb_lcd_24b};
      step();
    end
    lcd_de = 1'b0;
    for (int i = 0; i < hblank; i++) begin
      hsync = (i == 1) ? 1'b0 : 1'b1;
      step();
    end
    hsync = 1'b1;
  endtask

  task automatic vs_pulse();
    last_chk = acc;
    acc      = 32'h0;
    vsync    = 1'b0;
    step();
    step();
    vsync = 1'b1;
    step();
    step();
  endtask

  task automatic drive_frame(input int nlines);
    for (int y = 0; y < nlines; y++) drive_line(y, H, 6);
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    rgb_lcd_24b = 24'h0;
    hsync       = 1'b1;
    vsync       = 1'b1;
    lcd_de      = 1'b0;
    err_clr     = 1'b0;
    probe_x     = CW'(H - 1);
    probe_y     = CW'(V - 1);
    repeat (3) step();

    check("rst_pix_valid",  32'(pix_valid),  32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_pix_x",      32'(pix_x),      32'h0);
    check("rst_h_meas",     32'(h_meas),     32'h0);
    check("rst_v_meas",     32'(v_meas),     32'h0);
    check("rst_frame_chk",  frame_chk,       32'h0);
    check("rst_probe_rgb",  32'(probe_rgb),  32'h0);
    check("rst_err_flags",  32'(err_flags),  32'h0);
    check("rst_locked",     32'(locked),     32'h0);

    sys_rst_n = 1'b1;
    step();

    // Before the first vsync the monitor must ignore DE entirely.
    drive_line(0, H, 6);
    check("idle_no_pix",    32'(pv_cnt), 32'h0);
    check("idle_no_h_meas", 32'(h_meas), 32'h0);

    vs_pulse();
    check("first_vs_no_fd", 32'(fd_cnt), 32'h0);

    drive_frame(V);
    vs_pulse();
    check("f1_fd",     32'(fd_cnt),    32'd1);
    check("f1_h_meas", 32'(h_meas),    32'(H));
    check("f1_v_meas", 32'(v_meas),    32'(V));
    check("f1_chk",    frame_chk,      last_chk);
    check("f1_err",    32'(err_flags), 32'h0);
    check("f1_locked", 32'(locked),    32'h0);

    drive_frame(V);
    vs_pulse();
    check("f2_fd",     32'(fd_cnt), 32'd2);
    check("f2_locked", 32'(locked), 32'h1);

    drive_frame(V);
    vs_pulse();
    check("f3_fd",      32'(fd_cnt),    32'd3);
    check("f3_locked",  32'(locked),    32'h1);
    check("f3_err",     32'(err_flags), 32'h0);
    check("f3_chk",     frame_chk,      last_chk);
    check("probe_rgb",  32'(probe_rgb), 32'h002705A5);
    check("pix_count",  32'(pv_cnt),    32'(3 * V * H));

    // Frame with a short line 2.
    drive_line(0, H, 6);
    drive_line(1, H, 6);
    drive_line(2, H - 1, 6);
    check("short_err",    32'(err_flags), 32'h1);
    check("short_locked", 32'(locked),    32'h0);
    check("short_h_meas", 32'(h_meas),    32'(H - 1));
    for (int y = 3; y < V; y++) drive_line(y, H, 6);
    vs_pulse();
    check("short_sticky", 32'(err_flags), 32'h1);
    check("short_v_meas", 32'(v_meas),    32'(V));
    check("short_h_last", 32'(h_meas),    32'(H));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err",    32'(err_flags), 32'h0);
    check("clr_locked", 32'(locked),    32'h0);

    // Frame with one extra line.
    drive_frame(V + 1);
    vs_pulse();
    check("long_v_meas", 32'(v_meas),    32'(V + 1));
    check("long_err",    32'(err_flags), 32'h2);
    check("long_locked", 32'(locked),    32'h0);
    drive_frame(V);
    vs_pulse();
    check("relock1", 32'(locked), 32'h0);
    drive_frame(V);
    vs_pulse();
    check("relock2",     32'(locked), 32'h1);
    check("relock_v",    32'(v_meas), 32'(V));
    check("relock_fd",   32'(fd_cnt), 32'd7);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_vlen", 32'(err_flags), 32'h0);

    // Last line's DE fall coincides with the vsync leading edge.
    for (int y = 0; y < V - 1; y++) drive_line(y, H, 6);
    drive_line(V - 1, H, 0);
    vs_pulse();
    check("sim_fd",     32'(fd_cnt),    32'd8);
    check("sim_v_meas", 32'(v_meas),    32'(V));
    check("sim_h_meas", 32'(h_meas),    32'(H));
    check("sim_err",    32'(err_flags), 32'h0);
    check("sim_locked", 32'(locked),    32'h1);
    check("sim_chk",    frame_chk,      last_chk);

    // DE rise to pix_valid latency.
    lcd_de      = 1'b1;
    rgb_lcd_24b = 24'h0000A5;
    step();
    check("lat_edge1", 32'(pix_valid), 32'h0);
    rgb_lcd_24b = 24'h0100A5;
    step();
    check("lat_edge2", 32'(pix_valid), 32'h1);
    check("lat_pix_x", 32'(pix_x),     32'h0);
    check("lat_data",  32'(pix_data),  32'h0000A5);
    for (int x = 2; x <= 400; x++) begin
      rgb_lcd_24b = {x[7:0], 8'h00, 8'hA5};
      step();
    end

    // Asynchronous reset mid-line.
    sys_rst_n = 1'b0;
    #1;
    check("arst_pix_valid", 32'(pix_valid), 32'h0);
    check("arst_pix_x",     32'(pix_x),     32'h0);
    check("arst_h_meas",    32'(h_meas),    32'h0);
    check("arst_v_meas",    32'(v_meas),    32'h0);
    check("arst_chk",       frame_chk,      32'h0);
    check("arst_probe",     32'(probe_rgb), 32'h0);
    check("arst_locked",    32'(locked),    32'h0);
    step();
    step();
    sys_rst_n = 1'b1;
    base = pv_cnt;
    drive_line(1, H, 6);
    check("post_rst_ignore", 32'(pv_cnt - base), 32'h0);
    check("post_rst_h_meas", 32'(h_meas),        32'h0);
    base = fd_cnt;
    vs_pulse();
    check("post_rst_no_fd", 32'(fd_cnt - base), 32'h0);
    base = pv_cnt;
    drive_line(0, H, 6);
    check("post_rst_pix", 32'(pv_cnt - base), 32'(H));

    // Counter saturation on an over-long line.
    drive_line(1, 2050, 6);
    check("sat_h_meas", 32'(h_meas),    32'd2047);
    check("sat_err",    32'(err_flags), 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
